multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RISC-V control unit, for the cache-integrated datapath.
- One Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port.
- Stalls on a cache `mem_ready` handshake.
- ALU control width is parametrised; an optional stall-cycle counter is included.

Parameters:
- ALU_CTRL_W, 3, width of alu_control; must be >= 3; upper bits zero.
- CNT_W, 16, width of stall counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  instruction opcode
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  cache has completed current read/write this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction/OldPC register enable
- reg_write  out  1  register file write enable
- result_src  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=ImmExt, 10=constant 4
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- alu_control  out  ALU_CTRL_W  000=add, 001=sub, 010=and, 011=or, 101=slt
- illegal_op  out  1  one-cycle pulse on an unsupported opcode in DECODE

Behaviour:
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- imm_src is combinational from op: lw/I-ALU=00, sw=01, beq=10, jal=11, others=00.
- States, with outputs not listed = 0 / 00:
  - FETCH: adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, aluop=add, result_src=10. ir_write=pc_write=mem_ready. Stays in FETCH while !mem_ready; on mem_ready -> DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, add. Transitions:
    - lw/sw -> MEMADR
    - R -> EXECR
    - I-ALU -> EXECI
    - beq -> BEQ
    - jal -> JAL
    - other -> FETCH, with illegal_op=1
  - MEMADR: alu_src_a=10, alu_src_b=01, add. lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: adr_src=1, mem_read=1, result_src=00. Holds until mem_ready, then -> MEMWB.
  - MEMWB: result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE: adr_src=1, mem_write=1, result_src=00. Holds until mem_ready, then -> FETCH.
  - EXECR: alu_src_a=10, alu_src_b=00, funct-decode -> ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, funct-decode -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero -> FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 -> ALUWB.
- Funct-decode of alu_control by funct3:
  - 000: sub if (op[5] & funct7b5), else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Other funct3: add.
- mem_read/mem_write stay asserted and stable for every stalled cycle; ir_write/pc_write never assert in FETCH without mem_ready.
- Reset, at any time including mid-stall: state -> FETCH asynchronously. While rst=1, all of pc_write, ir_write, mem_read, mem_write, reg_write and illegal_op are forced 0; all select fields read 00 and alu_control reads 0.
- First FETCH request is issued in the first cycle after rst deasserts.
- Latency with mem_ready=1 every request:
  - lw: 5 cycles
  - sw: 4 cycles
  - R/I: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
  - Each stalled cycle adds 1.
- Unreachable state encodings -> FETCH on the next edge.

Optional Feature:
- Macro: CU_STALL_CNT_EN.
- Defined: adds output `stall_cycles [CNT_W-1:0]`.
  - Increments every cycle the FSM is in FETCH/MEMREAD/MEMWRITE with mem_ready=0.
  - Saturates at all-ones.
  - Cleared to 0 by rst.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Reset: hold rst=1 mid-MEMREAD stall, then release -> all enables 0 during reset; cycle 1 after release is FETCH with mem_read=1, adr_src=0.
- add x (op=0110011, funct3=000, funct7b5=0), mem_ready=1 -> FETCH, DECODE, EXECR with alu_control=000, ALUWB with reg_write=1; 4 cycles total. With funct7b5=1 -> alu_control=001.
- lw with mem_ready low for 3 cycles in MEMREAD -> mem_read=1, adr_src=1 held 4 cycles; MEMWB result_src=01, reg_write=1; total 8 cycles. stall_cycles=3 when enabled.
- beq: zero=1 -> pc_write=1 in BEQ with alu_control=001; repeat with zero=0 -> pc_write=0. Both return to FETCH.
- jal -> imm_src=11; JAL asserts pc_write with alu_src_a=01, alu_src_b=10; ALUWB reg_write=1 next.
- op=1111111 -> illegal_op=1 for exactly the DECODE cycle, no reg/mem write; next state FETCH.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore-FSM control unit for the multi-cycle RISC-V datapath. The datapath
//   has one shared ALU and one unified memory port behind a cache. The FSM
//   steps through fetch, decode, execute, memory and writeback. It stalls in
//   the memory-access states until the cache asserts mem_ready.
//
//   Parameters:
//     ALU_CTRL_W  width of alu_control (>= 3, upper bits driven 0)
//     CNT_W       width of stall_cycles (only with CU_STALL_CNT_EN)
//
//   Ports:
//     clk, rst            clock (rising edge), async active-high reset
//     op, funct3, funct7b5 instruction fields
//     zero                ALU zero flag, used by beq
//     mem_ready           cache completed the current access this cycle
//     pc_write, ir_write, reg_write, mem_read, mem_write   enables
//     adr_src, result_src, alu_src_a, alu_src_b, imm_src   mux selects
//     alu_control         000 add, 001 sub, 010 and, 011 or, 101 slt
//     illegal_op          one-cycle pulse in DECODE for unsupported opcodes
//
//   Optional feature (macro CU_STALL_CNT_EN):
//     stall_cycles        saturating count of cycles spent waiting on the
//                         cache in FETCH/MEMREAD/MEMWRITE; cleared by rst.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_op
`ifdef CU_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles
`endif
);

    if (ALU_CTRL_W < 3 || CNT_W < 1) begin : g_param_check
        $error("multicycle_control_unit: ALU_CTRL_W must be >= 3 and CNT_W >= 1");
    end

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] alu_op;
    logic [2:0] funct_alu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // ALU operation for the R-type / I-ALU execute states. funct7b5 only
    // selects sub for R-type (op[5]=1); for I-type addi it is part of the imm.
    always_comb begin
        funct_alu = ALU_ADD;
        unique case (funct3)
            3'b000:  funct_alu = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d     = S_FETCH;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        alu_op      = ALU_ADD;
        illegal_op  = 1'b0;
        alu_control = '0;

        unique case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase

        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_d    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                state_d  = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = funct_alu;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = funct_alu;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = ALU_SUB;
                pc_write  = zero;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase

        alu_control[2:0] = alu_op;

        // The state register already sits in FETCH during reset, but FETCH
        // drives mem_read; reset must hold every output quiet.
        if (rst) begin
            pc_write    = 1'b0;
            adr_src     = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            imm_src     = 2'b00;
            illegal_op  = 1'b0;
            alu_control = '0;
        end
    end

`ifdef CU_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             waiting;

    always_comb begin
        waiting = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                   (state_q == S_MEMWRITE)) && !mem_ready;
        stall_cycles_d = stall_cycles_q;
        if (waiting && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cycles_q <= '0;
        else     stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    op = 7'b0110011;
    logic [2:0]    funct3 = 3'b000;
    logic          funct7b5 = 1'b0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]    result_src, alu_src_a, alu_src_b, imm_src;
    logic [AW-1:0] alu_control;
    logic          illegal_op;
`ifdef CU_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [18:0] exp_q[$];
    string       tag_q[$];

    multicycle_control_unit #(.ALU_CTRL_W(AW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
        .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .illegal_op(illegal_op)
`ifdef CU_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Packed view: {pcw, adr, mrd, mwr, irw, rw, ill, rs, sa, sb, imm, alu}
    function automatic logic [18:0] ev(input logic pcw, input logic adr,
        input logic mrd, input logic mwr, input logic irw, input logic rw,
        input logic ill, input logic [1:0] rs, input logic [1:0] sa,
        input logic [1:0] sb, input logic [3:0] alu);
        return {pcw, adr, mrd, mwr, irw, rw, ill, rs, sa, sb, 2'b00, alu};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Canonical per-state expectations.
    function automatic logic [18:0] e_fetch(input logic rdy);
        return ev(rdy, 0, 1, 0, rdy, 0, 0, 2'b10, 2'b00, 2'b10, 4'd0);
    endfunction
    function automatic logic [18:0] e_decode(input logic ill);
        return ev(0, 0, 0, 0, 0, 0, ill, 2'b00, 2'b01, 2'b01, 4'd0);
    endfunction
    function automatic logic [18:0] e_aluwb();
        return ev(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0);
    endfunction
    function automatic logic [18:0] e_memadr();
        return ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0);
    endfunction

    // One clock cycle: drive mem_ready, queue the expected output vector,
    // compare at the falling edge, then advance past the rising edge.
    task automatic step(input logic rdy, input logic [18:0] e, input string tag);
        logic [18:0] got, want;
        string       t;
        mem_ready = rdy;
        want = e;
        if (!rst) want[5:4] = imm_of(op);
        exp_q.push_back(want);
        tag_q.push_back(tag);
        @(negedge clk);
        got = {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               illegal_op, result_src, alu_src_a, alu_src_b, imm_src, alu_control};
        want = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s got=%b expected=%b", t, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
    endtask

    initial begin
        // Reset held: everything quiet even though the FSM sits in FETCH.
        step(1, '0, "reset_hold");
        rst = 1'b0;

        // add x: 4 cycles, then sub with funct7b5=1.
        set_instr(7'b0110011, 3'b000, 0, 0);
        step(1, e_fetch(1), "add_fetch_first");
        step(1, e_decode(0), "add_decode");
        step(1, ev(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,4'b0000), "add_execr");
        step(1, e_aluwb(), "add_aluwb");
        set_instr(7'b0110011, 3'b000, 1, 0);
        step(1, e_fetch(1), "sub_fetch");
        step(1, e_decode(0), "sub_decode");
        step(1, ev(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,4'b0001), "sub_execr");
        step(1, e_aluwb(), "sub_aluwb");
        // R-type and/or.
        set_instr(7'b0110011, 3'b111, 0, 0);
        step(1, e_fetch(1), "and_fetch");
        step(1, e_decode(0), "and_decode");
        step(1, ev(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,4'b0010), "and_execr");
        step(1, e_aluwb(), "and_aluwb");

        // I-ALU: ori, slti, addi with funct7b5=1 (must stay add).
        set_instr(7'b0010011, 3'b110, 0, 0);
        step(1, e_fetch(1), "ori_fetch");
        step(1, e_decode(0), "ori_decode");
        step(1, ev(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,4'b0011), "ori_execi");
        step(1, e_aluwb(), "ori_aluwb");
        set_instr(7'b0010011, 3'b010, 0, 0);
        step(1, e_fetch(1), "slti_fetch");
        step(1, e_decode(0), "slti_decode");
        step(1, ev(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,4'b0101), "slti_execi");
        step(1, e_aluwb(), "slti_aluwb");
        set_instr(7'b0010011, 3'b000, 1, 0);
        step(1, e_fetch(1), "addi_f7_fetch");
        step(1, e_decode(0), "addi_f7_decode");
        step(1, ev(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,4'b0000), "addi_f7_execi");
        step(1, e_aluwb(), "addi_f7_aluwb");

        // lw with 3 stalled MEMREAD cycles: 8 cycles total.
        set_instr(7'b0000011, 3'b010, 0, 0);
        step(1, e_fetch(1), "lw_fetch");
        step(1, e_decode(0), "lw_decode");
        step(1, e_memadr(), "lw_memadr");
        for (int i = 0; i < 3; i++)
            step(0, ev(0,1,1,0,0,0,0,2'b00,2'b00,2'b00,4'd0), $sformatf("lw_memread_stall%0d", i));
        step(1, ev(0,1,1,0,0,0,0,2'b00,2'b00,2'b00,4'd0), "lw_memread_done");
`ifdef CU_STALL_CNT_EN
        n_cmp++;
        assert (stall_cycles === 16'd3) else begin
            n_bad++;
            $error("FAIL stall_cycles got=%0d expected=3", stall_cycles);
        end
`endif
        step(1, ev(0,0,0,0,0,1,0,2'b01,2'b00,2'b00,4'd0), "lw_memwb");

        // sw with one stalled MEMWRITE cycle, and a stalled FETCH first.
        set_instr(7'b0100011, 3'b010, 0, 0);
        step(0, e_fetch(0), "sw_fetch_stall");
        step(1, e_fetch(1), "sw_fetch");
        step(1, e_decode(0), "sw_decode");
        step(1, e_memadr(), "sw_memadr");
        step(0, ev(0,1,0,1,0,0,0,2'b00,2'b00,2'b00,4'd0), "sw_memwrite_stall");
        step(1, ev(0,1,0,1,0,0,0,2'b00,2'b00,2'b00,4'd0), "sw_memwrite_done");

        // beq taken and not taken.
        set_instr(7'b1100011, 3'b000, 0, 1);
        step(1, e_fetch(1), "beq_t_fetch");
        step(1, e_decode(0), "beq_t_decode");
        step(1, ev(1,0,0,0,0,0,0,2'b00,2'b10,2'b00,4'b0001), "beq_t_beq");
        set_instr(7'b1100011, 3'b000, 0, 0);
        step(1, e_fetch(1), "beq_nt_fetch");
        step(1, e_decode(0), "beq_nt_decode");
        step(1, ev(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,4'b0001), "beq_nt_beq");

        // jal.
        set_instr(7'b1101111, 3'b000, 0, 0);
        step(1, e_fetch(1), "jal_fetch");
        step(1, e_decode(0), "jal_decode");
        step(1, ev(1,0,0,0,0,0,0,2'b00,2'b01,2'b10,4'd0), "jal_jal");
        step(1, e_aluwb(), "jal_aluwb");

        // Illegal opcode: pulse in DECODE only, straight back to FETCH.
        set_instr(7'b1111111, 3'b000, 0, 0);
        step(1, e_fetch(1), "ill_fetch");
        step(1, e_decode(1), "ill_decode");
        step(0, e_fetch(0), "ill_back_to_fetch");

        // Reset asserted mid MEMREAD stall, then released.
        set_instr(7'b0000011, 3'b010, 0, 0);
        step(1, e_fetch(1), "rst_lw_fetch");
        step(1, e_decode(0), "rst_lw_decode");
        step(1, e_memadr(), "rst_lw_memadr");
        step(0, ev(0,1,1,0,0,0,0,2'b00,2'b00,2'b00,4'd0), "rst_lw_memread_stall");
        rst = 1'b1;
        step(0, '0, "rst_mid_stall_0");
        step(1, '0, "rst_mid_stall_1");
`ifdef CU_STALL_CNT_EN
        n_cmp++;
        assert (stall_cycles === 16'd0) else begin
            n_bad++;
            $error("FAIL stall_cycles_rst got=%0d expected=0", stall_cycles);
        end
`endif
        rst = 1'b0;
        step(0, e_fetch(0), "after_rst_fetch");
        step(1, e_fetch(1), "after_rst_fetch_ready");
        step(1, e_decode(0), "after_rst_decode");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
